fetch_inst_buffer: RTL and testbench

FETCH_INST_BUFFER -- requirements
Module: fetch_inst_buffer

---
 rtl/fetch_inst_buffer_if.sv | 28 ++
 rtl/fetch_inst_buffer.sv | 107 ++++++++++
 tb/tb_fetch_inst_buffer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_inst_buffer_if.sv
// Fetch-to-decode handshake bundle for fetch_inst_buffer: two enqueue slots
// from fetch, two presented entries toward decode, plus the full/ready controls.
interface fetch_inst_buffer_if #(
    parameter int DATA_W = 100
);
    logic              in0_valid;
    logic [DATA_W-1:0] in0_data;
    logic              in1_valid;
    logic [DATA_W-1:0] in1_data;
    logic              full;
    logic              out0_valid;
    logic [DATA_W-1:0] out0_data;
    logic              out1_valid;
    logic [DATA_W-1:0] out1_data;
    logic              out_ready;

    // Driven by the fetch/decode side
    modport master (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready,
        input  full, out0_valid, out0_data, out1_valid, out1_data
    );

    // Driven by the buffer
    modport slave (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
        output full, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/fetch_inst_buffer.sv
// Two-in/two-out circular instruction queue between fetch and decode.
// Optional full-cycle counter enabled by defining FIB_STALL_CNT_EN.
module fetch_inst_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    fetch_inst_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     count_q;

    logic              full;
    logic              enq_en;
    logic              deq_en;
    logic [1:0]        enq_n;
    logic [1:0]        deq_n;
    logic              wr0_en;
    logic              wr1_en;
    logic [DATA_W-1:0] wr0_data;
    logic [AW-1:0]     tail_p1;
    logic [AW-1:0]     head_p1;

    // Full leaves room for one more pair, so an accepted pair can never overflow.
    assign full    = count_q > CW'(DEPTH - 2);
    assign enq_en  = !full && !flush;
    assign deq_en  = bus.out_ready && !flush;
    assign tail_p1 = tail + AW'(1);
    assign head_p1 = head + AW'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        enq_n    = 2'd0;
        deq_n    = 2'd0;
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = bus.in1_data;
        if (enq_en) begin
            enq_n  = {1'b0, bus.in0_valid} + {1'b0, bus.in1_valid};
            wr0_en = bus.in0_valid || bus.in1_valid;
            wr1_en = bus.in0_valid && bus.in1_valid;
        end
        if (bus.in0_valid) begin
            wr0_data = bus.in0_data;
        end
        if (deq_en) begin
            deq_n = {1'b0, bus.out0_valid} + {1'b0, bus.out1_valid};
        end
    end

    // NOTE: payload RAM has no reset; valid flags derived from count_q qualify its contents.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem[tail] <= wr0_data;
        end
        if (wr1_en) begin
            mem[tail_p1] <= bus.in1_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + AW'(deq_n);
            tail    <= tail + AW'(enq_n);
            count_q <= count_q + CW'(enq_n) - CW'(deq_n);
        end
    end

    // Outputs read only registered storage, so a fresh write appears one cycle later.
    assign bus.full       = full;
    assign bus.out0_valid = count_q != '0;
    assign bus.out1_valid = count_q >= CW'(2);
    assign bus.out0_data  = mem[head];
    assign bus.out1_data  = mem[head_p1];
    assign count          = count_q;

`ifdef FIB_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (full && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Directed self-checking bench for fetch_inst_buffer (DEPTH=16, DATA_W=100).
module tb_fetch_inst_buffer;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 100;

`ifdef FIB_STALL_CNT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        flush;
    logic [4:0]  count;
    logic [31:0] stall_cnt;
    int          n_checks;
    int          n_errors;
    int          n_push;
    int          n_pop;

    fetch_inst_buffer_if #(.DATA_W(DATA_W)) bus ();

    fetch_inst_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Payload {pc, inst, pred_taken, pred_addr, is_j, is_br, j_bad_addr}
    function automatic logic [DATA_W-1:0] mk(input logic [31:0] pc);
        return {pc, ~pc, 1'b1, pc + 32'h40, 3'b010};
    endfunction

    function automatic logic [31:0] st(input int v);
        return STALL_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush         = 1'b0;
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in0_data  = '0;
        bus.in1_data  = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drive_pair(input logic [31:0] pc0, input logic [31:0] pc1);
        bus.in0_valid = 1'b1;
        bus.in1_valid = 1'b1;
        bus.in0_data  = mk(pc0);
        bus.in1_data  = mk(pc1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();

        // Reset overrides a concurrent flush, enqueue and dequeue
        rst = 1'b1;
        flush = 1'b1;
        drive_pair(32'h9000, 32'h9004);
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        idle();
        check("rst_count", count, 0);
        check("rst_out0_valid", bus.out0_valid, 0);
        check("rst_out1_valid", bus.out1_valid, 0);
        check("rst_full", bus.full, 0);
        check("rst_stall", stall_cnt, 0);

        // Pair enqueue; outputs must not bypass in the write cycle
        drive_pair(32'h100, 32'h104);
        #1;
        check("no_bypass_out0_valid", bus.out0_valid, 0);
        cyc();
        idle();
        check("pair_count", count, 2);
        check("pair_out0_valid", bus.out0_valid, 1);
        check("pair_out1_valid", bus.out1_valid, 1);
        check("pair_out0_pc", bus.out0_data[99:68], 32'h100);
        check("pair_out1_pc", bus.out1_data[99:68], 32'h104);
        check("pair_out0_data", bus.out0_data, mk(32'h100));
        check("pair_out1_data", bus.out1_data, mk(32'h104));

        flush = 1'b1;
        cyc();
        idle();
        check("flush_empty_count", count, 0);

        // Fill to DEPTH-1
        for (int i = 0; i < 7; i++) begin
            drive_pair(32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i));
            cyc();
        end
        idle();
        check("fill14_count", count, 14);
        check("fill14_full", bus.full, 0);
        bus.in0_valid = 1'b1;
        bus.in0_data  = mk(32'h1038);
        cyc();
        idle();
        check("fill15_count", count, 15);
        check("fill15_full", bus.full, 1);

        // Pair presented while full is dropped
        drive_pair(32'h2000, 32'h2004);
        cyc();
        idle();
        check("drop_count", count, 15);
        check("drop_out0_pc", bus.out0_data[99:68], 32'h1000);
        check("drop_out1_pc", bus.out1_data[99:68], 32'h1004);
        repeat (6) cyc();
        check("stall_7", stall_cnt, st(7));

        // Drain three pairs; the first dequeue edge still sees full
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        idle();
        check("drain_count", count, 9);
        check("drain_out0_pc", bus.out0_data[99:68], 32'h1018);
        check("drain_full", bus.full, 0);
        check("drain_stall", stall_cnt, st(8));

        // Flush beats concurrent enqueue and dequeue; stall count kept
        flush = 1'b1;
        drive_pair(32'h3000, 32'h3004);
        bus.out_ready = 1'b1;
        cyc();
        idle();
        check("flush_count", count, 0);
        check("flush_out0_valid", bus.out0_valid, 0);
        check("flush_full", bus.full, 0);
        check("flush_stall", stall_cnt, st(8));

        // Slot-1-only enqueue lands at the tail
        bus.in1_valid = 1'b1;
        bus.in1_data  = mk(32'h204);
        cyc();
        idle();
        check("in1_only_count", count, 1);
        check("in1_only_out0_valid", bus.out0_valid, 1);
        check("in1_only_out0_pc", bus.out0_data[99:68], 32'h204);
        check("in1_only_out1_valid", bus.out1_valid, 0);

        // Stream continues at pc 0x204 + 4*k; walk head and tail across the wrap
        n_push = 1;
        n_pop  = 0;
        for (int i = 0; i < 6; i++) begin
            drive_pair(32'h204 + 32'(4 * n_push), 32'h208 + 32'(4 * n_push));
            n_push += 2;
            cyc();
        end
        idle();
        check("wrap_pre_count", count, 13);
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        n_pop = 8;
        idle();
        check("wrap_start_count", count, 5);
        check("wrap_start_out0_pc", bus.out0_data[99:68], 32'h204 + 32'(4 * n_pop));
        for (int i = 0; i < 5; i++) begin
            drive_pair(32'h204 + 32'(4 * n_push), 32'h208 + 32'(4 * n_push));
            bus.out_ready = 1'b1;
            cyc();
            n_push += 2;
            n_pop  += 2;
            check($sformatf("wrap%0d_count", i), count, 5);
            check($sformatf("wrap%0d_out0_pc", i), bus.out0_data[99:68], 32'h204 + 32'(4 * n_pop));
            check($sformatf("wrap%0d_out1_pc", i), bus.out1_data[99:68], 32'h208 + 32'(4 * n_pop));
        end
        idle();

        // Reset mid-run clears occupancy and the stall counter
        rst = 1'b1;
        drive_pair(32'h4000, 32'h4004);
        cyc();
        rst = 1'b0;
        idle();
        check("rst2_count", count, 0);
        check("rst2_out0_valid", bus.out0_valid, 0);
        check("rst2_stall", stall_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
